// File: rtl/instruction_fetch.sv
// instruction_fetch: in-order instruction fetch unit with a 2-deep request
// window. Every response has a free buffer slot when it arrives.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   stall                    decode cannot take the presented instruction
//   redirect, redirect_address  taken branch / jal / jalr from execute
//   imem_req, imem_addr      request to instruction memory (word aligned)
//   imem_ready               memory accepts the request this cycle
//   imem_rvalid, imem_rdata  in-order response from instruction memory
//   valid, instruction, pc_address  head of the instruction buffer to decode
//   misaligned_trap          (FETCH_MISALIGN_TRAP_EN only) misaligned redirect
//
// Build option: define FETCH_MISALIGN_TRAP_EN to trap and halt on redirects
// whose target is not word aligned; otherwise the low two bits are masked.

module instruction_fetch #(
  parameter int unsigned          DataWidth   = 32,
  parameter logic [DataWidth-1:0] ResetVector = DataWidth'(32'h0000_0000)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 redirect,
  input  logic [DataWidth-1:0] redirect_address,
  output logic                 imem_req,
  output logic [DataWidth-1:0] imem_addr,
  input  logic                 imem_ready,
  input  logic                 imem_rvalid,
  input  logic [DataWidth-1:0] imem_rdata,
  output logic                 valid,
  output logic [DataWidth-1:0] instruction,
  output logic [DataWidth-1:0] pc_address
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic                 misaligned_trap
`endif
);

  localparam logic [1:0] StBoot  = 2'd0;
  localparam logic [1:0] StFetch = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;

  localparam logic [DataWidth-1:0] Nop       = DataWidth'(32'h0000_0013);
  localparam logic [DataWidth-1:0] PcStep    = DataWidth'(4);
  localparam logic [DataWidth-1:0] AlignMask = ~DataWidth'(3);

  logic [1:0]           state_q, state_n;
  logic [DataWidth-1:0] fetch_pc_q, fetch_pc_n;
  logic [1:0]           out_cnt_q, out_cnt_n;
  logic [DataWidth-1:0] aq_q [2];
  logic [DataWidth-1:0] aq_n [2];

  // Buffer slot 0 lives directly in the valid/instruction/pc_address flops.
  logic                 valid_n;
  logic [DataWidth-1:0] instruction_n, pc_address_n;
  logic                 buf1_valid_q, buf1_valid_n;
  logic [DataWidth-1:0] buf1_instr_q, buf1_instr_n;
  logic [DataWidth-1:0] buf1_pc_q, buf1_pc_n;

  logic                 imem_req_n;
  logic [DataWidth-1:0] imem_addr_n;
  logic                 halt_n;

  logic                 accept_c, rsp_live_c, consume_c, rsp_write_c;
  logic [DataWidth-1:0] target_c;
  logic [1:0]           aq_occ_c;
  logic [2:0]           occ_sum_c;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic halt_q;
  logic trap_n;
  logic misaligned_c;
`endif

  // Next-state, queue/buffer update and next-output decode.
  always_comb begin
    state_n       = state_q;
    fetch_pc_n    = fetch_pc_q;
    out_cnt_n     = out_cnt_q;
    aq_n          = aq_q;
    valid_n       = valid;
    instruction_n = instruction;
    pc_address_n  = pc_address;
    buf1_valid_n  = buf1_valid_q;
    buf1_instr_n  = buf1_instr_q;
    buf1_pc_n     = buf1_pc_q;
    halt_n        = 1'b0;

    accept_c    = imem_req & imem_ready;
    rsp_live_c  = imem_rvalid & (out_cnt_q != 2'd0);
    consume_c   = valid & ~stall;
    rsp_write_c = rsp_live_c & (state_q == StFetch);

`ifdef FETCH_MISALIGN_TRAP_EN
    misaligned_c = redirect & (redirect_address[1:0] != 2'b00);
    target_c     = redirect_address;
    trap_n       = misaligned_c;
    halt_n       = halt_q;
    if (redirect) halt_n = misaligned_c;
`else
    target_c = redirect_address & AlignMask;
`endif

    // Outstanding count also serves as the drain count after a redirect.
    out_cnt_n = out_cnt_q + 2'(accept_c) - 2'(rsp_live_c);

    // Address queue: pop on response, push the accepted address at the tail.
    aq_occ_c = out_cnt_q - 2'(rsp_live_c);
    if (rsp_live_c) aq_n[0] = aq_q[1];
    if (accept_c) begin
      if (aq_occ_c == 2'd0) aq_n[0] = imem_addr;
      else                  aq_n[1] = imem_addr;
    end

    // Buffer: consume shifts slot 1 into slot 0, then the response fills the tail.
    if (consume_c) begin
      valid_n       = buf1_valid_q;
      instruction_n = buf1_instr_q;
      pc_address_n  = buf1_pc_q;
      buf1_valid_n  = 1'b0;
    end
    if (rsp_write_c) begin
      if (!valid_n) begin
        valid_n       = 1'b1;
        instruction_n = imem_rdata;
        pc_address_n  = aq_q[0];
      end else begin
        buf1_valid_n = 1'b1;
        buf1_instr_n = imem_rdata;
        buf1_pc_n    = aq_q[0];
      end
    end
    if (redirect) begin
      valid_n      = 1'b0;
      buf1_valid_n = 1'b0;
    end
    if (!valid_n) begin
      instruction_n = Nop;
      pc_address_n  = '0;
    end

    if (accept_c) fetch_pc_n = fetch_pc_q + PcStep;
    if (redirect) fetch_pc_n = target_c;

    case (state_q)
      StBoot:  state_n = StFetch;
      StFetch: if (redirect) state_n = (out_cnt_n != 2'd0) ? StDrain : StFetch;
      StDrain: if (out_cnt_n == 2'd0) state_n = StFetch;
      default: state_n = StBoot;
    endcase

    // Request only while the in-flight plus buffered total leaves a slot free.
    occ_sum_c   = 3'(out_cnt_n) + 3'(valid_n) + 3'(buf1_valid_n);
    imem_req_n  = (state_n == StFetch) & ~halt_n & (occ_sum_c < 3'd2);
    imem_addr_n = fetch_pc_n;
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StBoot;
      fetch_pc_q   <= ResetVector;
      out_cnt_q    <= 2'd0;
      aq_q[0]      <= '0;
      aq_q[1]      <= '0;
      valid        <= 1'b0;
      instruction  <= Nop;
      pc_address   <= '0;
      buf1_valid_q <= 1'b0;
      buf1_instr_q <= Nop;
      buf1_pc_q    <= '0;
      imem_req     <= 1'b0;
      imem_addr    <= ResetVector;
    end else begin
      state_q      <= state_n;
      fetch_pc_q   <= fetch_pc_n;
      out_cnt_q    <= out_cnt_n;
      aq_q[0]      <= aq_n[0];
      aq_q[1]      <= aq_n[1];
      valid        <= valid_n;
      instruction  <= instruction_n;
      pc_address   <= pc_address_n;
      buf1_valid_q <= buf1_valid_n;
      buf1_instr_q <= buf1_instr_n;
      buf1_pc_q    <= buf1_pc_n;
      imem_req     <= imem_req_n;
      imem_addr    <= imem_addr_n;
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  // Trap pulse and halt flag held until the next aligned redirect.
  always_ff @(posedge clk) begin
    if (rst) begin
      halt_q          <= 1'b0;
      misaligned_trap <= 1'b0;
    end else begin
      halt_q          <= halt_n;
      misaligned_trap <= trap_n;
    end
  end
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
`timescale 1ns/1ps
// Testbench for instruction_fetch: randomized memory and decode behaviour,
// with a scoreboard of the contiguous pc stream decode should observe.

module tb_instruction_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, stall, redirect;
  logic [31:0] redirect_address;
  logic        imem_req, imem_ready, imem_rvalid, valid;
  logic [31:0] imem_addr, imem_rdata, instruction, pc_address;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        misaligned_trap;
`endif

  always #5 clk = ~clk;

  instruction_fetch #(.DataWidth(32), .ResetVector(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
    .redirect_address(redirect_address),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .valid(valid), .instruction(instruction), .pc_address(pc_address)
`ifdef FETCH_MISALIGN_TRAP_EN
    , .misaligned_trap(misaligned_trap)
`endif
  );

  typedef struct { logic [31:0] addr; int due; } mreq_t;
  typedef struct { logic [31:0] pc; logic [31:0] ins; } exp_t;

  mreq_t       mq[$];      // requests accepted by the memory, in order
  exp_t        sb[$];      // instructions decode should see, in order
  logic [31:0] sb_tail;
  logic [31:0] exp_req;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          consumed = 0;
  int          rdy_pct = 100, lat_min = 1, lat_max = 1;
  logic        stall_v = 1'b0;
  bit          prev_hold = 0;
  logic [31:0] prev_addr;
  bit          rd_on_rsp = 0, rsp_redirect_hit = 0;
  logic [31:0] rd_on_rsp_addr;

  // Memory image: odd multiplier makes every word address map to a unique word.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock of stimulus: memory responder, decode inputs, request checking.
  task automatic step(input logic rd, input logic [31:0] ra);
    logic [31:0] tgt;
    bit acc;
    @(negedge clk);
    cyc++;
    if (prev_hold) begin
      check("req_hold", 32'(imem_req), 32'd1);
      check("addr_hold", imem_addr, prev_addr);
    end
    stall      = stall_v;
    imem_ready = ($urandom_range(99) < 32'(rdy_pct));
    if (rst) mq.delete();
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(mq[0].addr);
      void'(mq.pop_front());
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
    if (rd_on_rsp && imem_rvalid) begin
      rd = 1'b1;
      ra = rd_on_rsp_addr;
      rd_on_rsp = 0;
      rsp_redirect_hit = 1;
    end
    redirect         = rd;
    redirect_address = ra;
    acc = imem_req && imem_ready && !rst;
    if (acc) begin
      check("req_addr", imem_addr, exp_req);
      mq.push_back(mreq_t'{imem_addr, cyc + int'($urandom_range(32'(lat_max), 32'(lat_min)))});
      exp_req += 32'd4;
    end
    prev_hold = imem_req && !imem_ready && !rd && !rst;
    prev_addr = imem_addr;
    if (rd) begin
`ifdef FETCH_MISALIGN_TRAP_EN
      tgt = ra;
`else
      tgt = ra & ~32'd3;
`endif
      exp_req = tgt;
      sb.delete();
      sb_tail = tgt;
    end
    if (rst) begin
      exp_req = 32'd0;
      sb.delete();
      sb_tail = 32'd0;
    end
    while (sb.size() < 8) begin
      sb.push_back(exp_t'{sb_tail, mem_word(sb_tail)});
      sb_tail += 32'd4;
    end
  endtask

  // Monitor: compares every instruction decode consumes against the scoreboard.
  bit redir_seen = 0;
  always @(negedge clk) begin
    exp_t e;
    #1;
    if (rst) begin
      redir_seen = 0;
    end else begin
      if (redir_seen) check("valid_after_redirect", 32'(valid), 32'd0);
      if (!valid) check("nop_when_invalid", instruction, NOP);
      if (valid && !stall && !redirect) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_empty: got pc %h expected no instruction", pc_address);
        end else begin
          e = sb.pop_front();
          check("pc", pc_address, e.pc);
          check("instr", instruction, e.ins);
          consumed++;
        end
      end
      redir_seen = redirect;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit hit;
    logic [31:0] cap_i, cap_p;
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_address = '0;
    imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    exp_req = 32'd0; sb_tail = 32'd0;

    // Reset state
    repeat (3) step(1'b0, 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_instr", instruction, NOP);
    check("rst_pc", pc_address, 32'd0);
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_addr", imem_addr, 32'd0);
    rst = 1'b0;
    step(1'b0, 32'd0);
    check("boot_then_req", 32'(imem_req), 32'd1);
    check("boot_addr", imem_addr, 32'd0);

    // Straight-line fetch with a 1-cycle memory
    repeat (30) step(1'b0, 32'd0);
    check("throughput", 32'(consumed >= 12), 32'd1);

    // Stall with the buffer full
    stall_v = 1'b1;
    hit = 0;
    for (int i = 0; i < 20 && !hit; i++) begin
      step(1'b0, 32'd0);
      if (valid && !imem_req && mq.size() == 0) hit = 1;
    end
    check("stall_fill_reached", 32'(hit), 32'd1);
    cap_i = instruction; cap_p = pc_address;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 32'd0);
      check("stall_req", 32'(imem_req), 32'd0);
      check("stall_instr", instruction, cap_i);
      check("stall_pc", pc_address, cap_p);
    end
    stall_v = 1'b0;
    repeat (20) step(1'b0, 32'd0);

    // Redirect with two requests outstanding
    lat_min = 4; lat_max = 4;
    hit = 0;
    for (int i = 0; i < 20 && !hit; i++) begin
      step(1'b0, 32'd0);
      if (mq.size() == 2) hit = 1;
    end
    check("two_outstanding", 32'(hit), 32'd1);
    step(1'b1, 32'h100);
    step(1'b0, 32'd0);
    check("drain_req", 32'(imem_req), 32'd0);
    hit = 0;
    for (int i = 0; i < 20 && !hit; i++) begin
      if (imem_req) hit = 1;
      else step(1'b0, 32'd0);
    end
    check("drain_exit", 32'(hit), 32'd1);
    check("redirect_addr", imem_addr, 32'h100);
    repeat (20) step(1'b0, 32'd0);

    // Redirect coincident with a response while stalled
    lat_min = 1; lat_max = 1; stall_v = 1'b1;
    step(1'b1, 32'h180);
    rd_on_rsp = 1; rd_on_rsp_addr = 32'h200; rsp_redirect_hit = 0;
    for (int i = 0; i < 20 && !rsp_redirect_hit; i++) step(1'b0, 32'd0);
    check("rsp_redirect_hit", 32'(rsp_redirect_hit), 32'd1);
    rd_on_rsp = 0;
    step(1'b0, 32'd0);
    check("discard_valid", 32'(valid), 32'd0);
    stall_v = 1'b0;
    repeat (20) step(1'b0, 32'd0);

    // Random memory handshake, latency, stalls and aligned redirects
    rdy_pct = 50; lat_min = 1; lat_max = 4;
    step(1'b1, 32'hFFFF_FFF8);
    for (int i = 0; i < 2000; i++) begin
      stall_v = ($urandom_range(99) < 30);
      if ($urandom_range(99) < 3) step(1'b1, $urandom & ~32'd3);
      else                        step(1'b0, 32'd0);
    end

    // Misaligned redirect
    rdy_pct = 100; lat_min = 1; lat_max = 1; stall_v = 1'b0;
    repeat (5) step(1'b0, 32'd0);
    step(1'b1, 32'h102);
`ifdef FETCH_MISALIGN_TRAP_EN
    step(1'b0, 32'd0);
    check("trap_pulse", 32'(misaligned_trap), 32'd1);
    step(1'b0, 32'd0);
    check("trap_end", 32'(misaligned_trap), 32'd0);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 32'd0);
      check("halt_req", 32'(imem_req), 32'd0);
      check("halt_valid", 32'(valid), 32'd0);
    end
    step(1'b1, 32'h300);
`else
    hit = 0;
    for (int i = 0; i < 10 && !hit; i++) begin
      step(1'b0, 32'd0);
      if (imem_req) hit = 1;
    end
    check("mask_req", 32'(hit), 32'd1);
    check("mask_addr", imem_addr, 32'h100);
`endif
    repeat (20) step(1'b0, 32'd0);

    check("consumed_total", 32'(consumed >= 200), 32'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 The block SHALL take parameter DataWidth, default 32: width of addresses and instructions.
REQ-002 The block SHALL take parameter ResetVector, default 32'h0000_0000: first fetch address after reset.
REQ-003 The block SHALL have one clock and a synchronous active-high reset; all state updates on the rising edge of clk.
REQ-004 clk  in  1  clock.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 stall  in  1  decode cannot accept the presented instruction this cycle (load-use hazard).
REQ-007 redirect  in  1  taken branch, jal or jalr from execute; single-cycle pulse.
REQ-008 redirect_address  in  DataWidth  new fetch target.
REQ-009 imem_req  out  1  instruction-memory request.
REQ-010 imem_addr  out  DataWidth  request address, word aligned.
REQ-011 imem_ready  in  1  memory accepts the request this cycle.
REQ-012 imem_rvalid  in  1  response data valid; responses return in request order, at least 1 cycle after acceptance.
REQ-013 imem_rdata  in  DataWidth  response instruction word.
REQ-014 valid  out  1  instruction/pc_address hold a live instruction for decode.
REQ-015 instruction  out  DataWidth  instruction to decode; 32'h0000_0013 (NOP) whenever valid=0.
REQ-016 pc_address  out  DataWidth  address of the presented instruction.

Function
REQ-017 Request accepted when imem_req & imem_ready; otherwise imem_req and imem_addr SHALL be held stable.
REQ-018 Fetch PC SHALL advance by 4 on each accepted request, wrapping modulo 2^DataWidth.
REQ-019 Block SHALL keep a 2-entry in-order address queue of outstanding requests and a 2-entry instruction buffer {instruction, pc}.
REQ-020 imem_req SHALL assert only when (outstanding + buffered) < 2, so every response has a free buffer slot.
REQ-021 Each imem_rvalid response SHALL be written to the buffer tail with the pc from the address-queue head; valid asserts the cycle after imem_rvalid.
REQ-022 Buffer head SHALL be presented on instruction/pc_address; consumed when valid & !stall; held unchanged while stall=1.
REQ-023 Simultaneous consume and response SHALL be supported in the same cycle without loss or reorder.
REQ-024 States: BOOT (one cycle after reset, no request), FETCH (normal issue), DRAIN (discarding responses of killed requests).
REQ-025 BOOT -> FETCH unconditionally next cycle.
REQ-026 On redirect in FETCH: buffer flushed, valid=0 next cycle, fetch PC := redirect_address; to DRAIN if any request outstanding (including one accepted this cycle), else stay in FETCH and issue redirect_address next cycle.
REQ-027 In DRAIN: imem_req=0, every imem_rvalid discarded and the outstanding count decremented; when the count reaches 0, go to FETCH.
REQ-028 redirect in DRAIN SHALL overwrite the pending target and remain in DRAIN.
REQ-029 redirect SHALL take priority over stall and over a coincident imem_rvalid, whose data is discarded.
REQ-030 Redirect-to-first-request latency SHALL be 1 cycle when no requests are outstanding.

Reset
REQ-031 rst SHALL set state=BOOT, fetch PC=ResetVector, buffer and address queue empty, and the outstanding count to 0.
REQ-032 During and after rst: valid=0, instruction=NOP, pc_address=0, imem_req=0, imem_addr=ResetVector.
REQ-033 rst mid-operation SHALL abandon outstanding requests; later responses SHALL be dropped via the DRAIN count not being restored.
REQ-034 rst mid-operation SHALL therefore require the memory to be reset in the same cycle.

Configuration
REQ-035 With macro FETCH_MISALIGN_TRAP_EN defined, an extra output misaligned_trap (out 1) SHALL pulse for one cycle when redirect_address[1:0]!=0.
REQ-036 Under FETCH_MISALIGN_TRAP_EN, fetch SHALL halt (imem_req=0, valid=0) after the trap until the next aligned redirect.
REQ-037 Without FETCH_MISALIGN_TRAP_EN, redirect_address[1:0] SHALL be masked to 0 and no trap port exists.

Verification
REQ-038 Bench: reset, imem_ready=1, 1-cycle memory -> requests 0x0,0x4,0x8...; valid rises with pc_address 0x0 and instructions in order.
REQ-039 Bench: stall=1 for 5 cycles with the buffer full -> imem_req=0; instruction and pc_address stable; no loss after release.
REQ-040 Bench: redirect to 0x100 with 2 outstanding -> DRAIN; two responses dropped; next request 0x100; first valid pc_address=0x100.
REQ-041 Bench: redirect coincident with imem_rvalid and stall=1 -> response discarded; valid=0 next cycle.
REQ-042 Bench: imem_ready toggling randomly, variable 1-4 cycle latency -> pc sequence contiguous; instruction matches memory image at pc.
REQ-043 Bench: redirect_address 0x102 -> with macro, misaligned_trap pulse and fetch halts; without macro, next fetch 0x100.
